// File: rtl/rv_divider_if.sv
// rv_divider_if: request/result bundle for the iterative divider.
//   master modport (requester): drives start, is_signed, dividend, divisor;
//                               receives busy, done, quotient, remainder.
//   slave modport (divider):    the mirror image of master.
interface rv_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/rv_divider.sv
// rv_divider: fixed-latency restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit is produced per CALC cycle, so a result takes WIDTH CALC
// cycles plus one FIX cycle plus one DONE cycle, whatever the operands.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - rv_divider_if slave modport:
//          start/is_signed/dividend/divisor in (sampled only in IDLE),
//          busy (CALC or FIX), done (one-cycle pulse), quotient, remainder out
module rv_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  rv_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] quo_q,       quo_d;
  logic [WIDTH-1:0] div_q,       div_d;
  logic             q_neg_q,     q_neg_d;
  logic             r_neg_q,     r_neg_d;
  logic             div_zero_q,  div_zero_d;
  logic             ovf_q,       ovf_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // Next-state and datapath. quo_q starts out holding the dividend magnitude;
  // each step shifts its MSB into the partial remainder and a quotient bit in
  // at the bottom, so after WIDTH steps it holds the unsigned quotient.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
    shifted = {rem_q, quo_q[WIDTH-1]};
    // Extra top bit catches the borrow of the trial subtraction.
    diff    = {1'b0, shifted} - {2'b00, div_q};
    borrow  = diff[WIDTH+1];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          quo_d      = a_neg ? -bus.dividend : bus.dividend;
          div_d      = b_neg ? -bus.divisor  : bus.divisor;
          rem_d      = '0;
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          div_zero_d = (bus.divisor == '0);
          ovf_d      = bus.is_signed && (bus.dividend == INT_MIN) && (bus.divisor == '1);
          cnt_d      = CW'(WIDTH);
          busy_d     = 1'b1;
          state_d    = CALC;
        end
      end

      CALC: begin
        // When the subtraction borrows, the remainder fits in WIDTH bits
        // because it is smaller than the divisor.
        rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // Divide by zero leaves |dividend| in the remainder, so restoring the
        // dividend sign returns the original dividend.
        if (div_zero_q) begin
          quotient_d  = '1;
          remainder_d = r_neg_q ? -rem_q : rem_q;
        end else if (ovf_q) begin
          quotient_d  = INT_MIN;
          remainder_d = '0;
        end else begin
          quotient_d  = q_neg_q ? -quo_q : quo_q;
          remainder_d = r_neg_q ? -rem_q : rem_q;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register for the FSM and all datapath/output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_rv_divider.sv
// tb_rv_divider: directed tests for rv_divider (WIDTH=32).
// Latency is reported as the edge number, counted from the edge that sampled
// start, at which done is high when that edge arrives (WIDTH+2 = 34).
module tb_rv_divider;

  localparam int W = 32;

  logic clk;
  logic rst;

  rv_divider_if #(.WIDTH(W)) bus ();

  rv_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec;
  int n_miss;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launch one division and observe it #1 after every rising edge.
  // held goes low if quotient/remainder move before done appears.
  task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output int lat, output int busy_cnt, output int done_cnt,
                        output bit held);
    q = 'x;
    r = 'x;
    lat = -1;
    busy_cnt = 0;
    done_cnt = 0;
    held = 1'b1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 0; k < W + 8; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k + 1;
          q = bus.quotient;
          r = bus.remainder;
        end
      end else if (lat < 0 && (bus.quotient !== last_q || bus.remainder !== last_r)) begin
        held = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.busy !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    n_vec++;
    if (bus.done !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    n_vec++;
    if (bus.quotient !== '0) begin n_miss++; $display("[TB] FAIL reset_quotient: got %h expected 0", bus.quotient); end
    n_vec++;
    if (bus.remainder !== '0) begin n_miss++; $display("[TB] FAIL reset_remainder: got %h expected 0", bus.remainder); end
    @(negedge clk);
    rst = 1'b0;
    last_q = '0;
    last_r = '0;
  endtask

  task automatic test_unsigned();
    logic [W-1:0] q, r;
    int lat, bc, dc;
    bit held;
    do_div(1'b0, 32'd100, 32'd7, q, r, lat, bc, dc, held);
    n_vec++;
    if (q !== 32'd14) begin n_miss++; $display("[TB] FAIL udiv_q: got %h expected %h", q, 32'd14); end
    n_vec++;
    if (r !== 32'd2) begin n_miss++; $display("[TB] FAIL udiv_r: got %h expected %h", r, 32'd2); end
    n_vec++;
    if (lat != W + 2) begin n_miss++; $display("[TB] FAIL udiv_latency: got %0d expected %0d", lat, W + 2); end
    n_vec++;
    if (bc != W + 1) begin n_miss++; $display("[TB] FAIL udiv_busy_cycles: got %0d expected %0d", bc, W + 1); end
    n_vec++;
    if (dc != 1) begin n_miss++; $display("[TB] FAIL udiv_done_pulses: got %0d expected 1", dc); end
    n_vec++;
    if (!held) begin n_miss++; $display("[TB] FAIL udiv_hold: outputs moved before done, expected held at %h/%h", last_q, last_r); end
    last_q = 32'd14;
    last_r = 32'd2;

    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, q, r, lat, bc, dc, held);
    n_vec++;
    if (q !== 32'h0FFF_FFFF) begin n_miss++; $display("[TB] FAIL udiv_big_q: got %h expected 0fffffff", q); end
    n_vec++;
    if (r !== 32'hF) begin n_miss++; $display("[TB] FAIL udiv_big_r: got %h expected 0000000f", r); end
    n_vec++;
    if (!held) begin n_miss++; $display("[TB] FAIL udiv_big_hold: outputs moved before done, expected held at %h/%h", last_q, last_r); end
    last_q = 32'h0FFF_FFFF;
    last_r = 32'hF;
  endtask

  // Shared body for table-driven tasks would be a helper; each task below
  // keeps its own loop and compares.
  task automatic test_signed();
    logic [W-1:0] ta [3], tb [3], eq [3], er [3];
    logic [W-1:0] q, r;
    int lat, bc, dc;
    bit held;
    ta = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9};
    tb = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE};
    eq = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
    er = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      do_div(1'b1, ta[i], tb[i], q, r, lat, bc, dc, held);
      n_vec++;
      if (q !== eq[i]) begin n_miss++; $display("[TB] FAIL sdiv_q[%0d]: got %h expected %h", i, q, eq[i]); end
      n_vec++;
      if (r !== er[i]) begin n_miss++; $display("[TB] FAIL sdiv_r[%0d]: got %h expected %h", i, r, er[i]); end
      n_vec++;
      if (lat != W + 2) begin n_miss++; $display("[TB] FAIL sdiv_latency[%0d]: got %0d expected %0d", i, lat, W + 2); end
      last_q = eq[i];
      last_r = er[i];
    end
  endtask

  task automatic test_div_zero();
    logic       ts [3];
    logic [W-1:0] ta [3], er [3];
    logic [W-1:0] q, r;
    int lat, bc, dc;
    bit held;
    ts = '{1'b0, 1'b1, 1'b1};
    ta = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0001};
    er = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0001};
    for (int i = 0; i < 3; i++) begin
      do_div(ts[i], ta[i], 32'd0, q, r, lat, bc, dc, held);
      n_vec++;
      if (q !== 32'hFFFF_FFFF) begin n_miss++; $display("[TB] FAIL div0_q[%0d]: got %h expected ffffffff", i, q); end
      n_vec++;
      if (r !== er[i]) begin n_miss++; $display("[TB] FAIL div0_r[%0d]: got %h expected %h", i, r, er[i]); end
      n_vec++;
      if (lat != W + 2) begin n_miss++; $display("[TB] FAIL div0_latency[%0d]: got %0d expected %0d", i, lat, W + 2); end
      n_vec++;
      if (dc != 1) begin n_miss++; $display("[TB] FAIL div0_done_pulses[%0d]: got %0d expected 1", i, dc); end
      last_q = 32'hFFFF_FFFF;
      last_r = er[i];
    end
  endtask

  task automatic test_overflow();
    logic       ts [2];
    logic [W-1:0] eq [2], er [2];
    logic [W-1:0] q, r;
    int lat, bc, dc;
    bit held;
    ts = '{1'b1, 1'b0};
    eq = '{32'h8000_0000, 32'd0};
    er = '{32'd0,         32'h8000_0000};
    for (int i = 0; i < 2; i++) begin
      do_div(ts[i], 32'h8000_0000, 32'hFFFF_FFFF, q, r, lat, bc, dc, held);
      n_vec++;
      if (q !== eq[i]) begin n_miss++; $display("[TB] FAIL ovf_q[%0d]: got %h expected %h", i, q, eq[i]); end
      n_vec++;
      if (r !== er[i]) begin n_miss++; $display("[TB] FAIL ovf_r[%0d]: got %h expected %h", i, r, er[i]); end
      n_vec++;
      if (lat != W + 2) begin n_miss++; $display("[TB] FAIL ovf_latency[%0d]: got %0d expected %0d", i, lat, W + 2); end
      last_q = eq[i];
      last_r = er[i];
    end
  endtask

  // start held high with changing operands through CALC, FIX and DONE; it is
  // dropped in the first IDLE cycle, so no second division may begin.
  task automatic test_start_ignored();
    logic [W-1:0] q, r;
    int lat, dc, late_busy;
    q = 'x;
    r = 'x;
    lat = -1;
    dc = 0;
    late_busy = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd200;
    bus.divisor   = 32'd9;
    @(posedge clk);
    #1;
    for (int k = 0; k < W + 10; k++) begin
      if (lat < 0 || k < lat) begin
        bus.dividend  = 32'(k * 3 + 1);
        bus.divisor   = 32'(k + 2);
        bus.is_signed = k[0];
      end
      if (bus.done) begin
        dc++;
        if (lat < 0) begin
          lat = k + 1;
          q = bus.quotient;
          r = bus.remainder;
        end
      end
      if (lat >= 0 && k >= lat) begin
        bus.start = 1'b0;
        if (bus.busy) late_busy++;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    n_vec++;
    if (q !== 32'd22) begin n_miss++; $display("[TB] FAIL storm_q: got %h expected %h", q, 32'd22); end
    n_vec++;
    if (r !== 32'd2) begin n_miss++; $display("[TB] FAIL storm_r: got %h expected %h", r, 32'd2); end
    n_vec++;
    if (lat != W + 2) begin n_miss++; $display("[TB] FAIL storm_latency: got %0d expected %0d", lat, W + 2); end
    n_vec++;
    if (dc != 1) begin n_miss++; $display("[TB] FAIL storm_done_pulses: got %0d expected 1", dc); end
    n_vec++;
    if (late_busy != 0) begin n_miss++; $display("[TB] FAIL storm_restart: got %0d busy cycles after DONE expected 0", late_busy); end
    last_q = 32'd22;
    last_r = 32'd2;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r;
    int lat, bc, dc, stray_done;
    bit held;
    stray_done = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.busy !== 1'b0) begin n_miss++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
    n_vec++;
    if (bus.done !== 1'b0) begin n_miss++; $display("[TB] FAIL midrst_done: got %b expected 0", bus.done); end
    n_vec++;
    if (bus.quotient !== '0) begin n_miss++; $display("[TB] FAIL midrst_quotient: got %h expected 0", bus.quotient); end
    n_vec++;
    if (bus.remainder !== '0) begin n_miss++; $display("[TB] FAIL midrst_remainder: got %h expected 0", bus.remainder); end
    rst = 1'b0;
    for (int k = 0; k < W + 6; k++) begin
      if (bus.done || bus.busy) stray_done++;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (stray_done != 0) begin n_miss++; $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", stray_done); end
    last_q = '0;
    last_r = '0;
    do_div(1'b0, 32'd9, 32'd3, q, r, lat, bc, dc, held);
    n_vec++;
    if (q !== 32'd3) begin n_miss++; $display("[TB] FAIL postrst_q: got %h expected %h", q, 32'd3); end
    n_vec++;
    if (r !== 32'd0) begin n_miss++; $display("[TB] FAIL postrst_r: got %h expected %h", r, 32'd0); end
    n_vec++;
    if (lat != W + 2) begin n_miss++; $display("[TB] FAIL postrst_latency: got %0d expected %0d", lat, W + 2); end
    last_q = 32'd3;
    last_r = 32'd0;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rv_divider.md
RV_DIVIDER -- requirements
Module: rv_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: request a new division; sampled only in IDLE.
REQ-005 Port is_signed, input, 1 bit: 1 selects two's-complement DIV/REM, 0 selects unsigned DIVU/REMU; captured with start.
REQ-006 Port dividend, input, WIDTH bits: numerator; captured with start.
REQ-007 Port divisor, input, WIDTH bits: denominator; captured with start.
REQ-008 Port busy, output, 1 bit: high while a division is in progress (CALC or FIX).
REQ-009 Port done, output, 1 bit: one-cycle pulse marking quotient/remainder valid.
REQ-010 Port quotient, output, WIDTH bits: result quotient.
REQ-011 Port remainder, output, WIDTH bits: result remainder.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-013 IDLE with start=1 SHALL capture operands and is_signed, load the iteration counter with WIDTH, and go to CALC; start=0 SHALL stay in IDLE.
REQ-014 On capture, signed operands SHALL be converted to magnitudes, and the result signs SHALL be recorded: quotient sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend).
REQ-015 Each CALC cycle SHALL do one restoring shift-subtract step: shift the partial remainder left and take in the next dividend bit (MSB first); subtract the divisor magnitude; on no borrow, keep the difference and shift in quotient bit 1; otherwise keep the shifted value and shift in 0.
REQ-016 The counter SHALL decrement once per CALC cycle; after exactly WIDTH CALC cycles the FSM SHALL go to FIX.
REQ-017 FIX SHALL negate the quotient and/or remainder per the recorded signs (signed only), apply the special cases, register the results, and go to DONE.
REQ-018 DONE SHALL hold done=1 for exactly one cycle and then return to IDLE.
REQ-019 Latency SHALL be fixed and independent of operands: done is high on the (WIDTH+2)th rising edge after the edge that sampled start (WIDTH CALC + FIX + DONE).
REQ-020 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-021 start asserted while not in IDLE SHALL be ignored and SHALL NOT disturb the running division.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-023 quotient and remainder SHALL change only in FIX, and SHALL hold until the next FIX.
REQ-024 Divide by zero (either mode) SHALL give quotient = all ones and remainder = dividend, with the normal latency.
REQ-025 Signed overflow (dividend = -2^(WIDTH-1), divisor = -1) SHALL give quotient = -2^(WIDTH-1) and remainder = 0, with the normal latency.
REQ-026 All arithmetic SHALL be WIDTH bits, plus one guard bit in the subtractor for the borrow; a nonzero remainder's sign SHALL match the dividend, and the quotient SHALL truncate toward zero.

Reset
REQ-027 rst=1 on a rising edge SHALL force IDLE and clear busy=0, done=0, quotient=0, remainder=0 and the counter and internal registers, whatever the state.
REQ-028 Reset mid-operation SHALL abort the division with no done pulse; a start after reset deasserts SHALL run normally.
REQ-029 rst SHALL take priority over start in the same cycle.

Verification
REQ-030 Unsigned: start, is_signed=0, 100/7 -> done at edge WIDTH+2 (34 for WIDTH=32), quotient=14, remainder=2, busy high for 33 cycles.
REQ-031 Signed: is_signed=1, -7/2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF); then 7/-2 -> quotient=-3, remainder=1.
REQ-032 Divide by zero: 0x12345678/0 in both modes -> quotient=0xFFFFFFFF, remainder=0x12345678, same latency.
REQ-033 Overflow: is_signed=1, 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; same operands unsigned -> quotient=0, remainder=0x80000000.
REQ-034 start pulsed every cycle during a run with changed operands -> original result unchanged and exactly one done pulse per accepted start.
REQ-035 rst asserted at CALC cycle 10 -> next edge shows busy=0, done=0, outputs 0, and no done pulse; a following 9/3 start -> quotient=3, remainder=0.
